// File: rtl/mips_muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package mips_muldiv_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10
  } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the shared datapath: shift-add multiply or
// restoring divide on the double-width partial register {upper, lower}.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic               i_div,
  input  logic [2*WIDTH-1:0] i_part,
  input  logic [WIDTH-1:0]   i_opnd,
  output logic [2*WIDTH-1:0] o_part,
  output logic               o_qbit
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_trial;

  // Next partial value; the quotient bit is left for the caller to insert at bit 0
  always_comb begin
    w_sum   = {1'b0, i_part[2*WIDTH-1:WIDTH]} + {1'b0, i_opnd};
    // Upper half shifted left by one, with the incoming dividend bit, minus the divisor
    w_trial = i_part[2*WIDTH-1:WIDTH-1] - {1'b0, i_opnd};
    o_qbit  = 1'b0;
    o_part  = i_part;
    if (i_div) begin
      o_qbit = ~w_trial[WIDTH];
      if (~w_trial[WIDTH]) begin
        o_part = {w_trial[WIDTH-1:0], i_part[WIDTH-2:0], 1'b0};
      end else begin
        o_part = {i_part[2*WIDTH-2:0], 1'b0};
      end
    end else begin
      if (i_part[0]) begin
        o_part = {w_sum, i_part[WIDTH-1:1]};
      end else begin
        o_part = {1'b0, i_part[2*WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencer for the EX stage: FSM, iteration counter, sign
// handling and the architectural HI/LO registers.
module muldiv_ctrl
  import mips_muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e             r_state;
  state_e             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_div;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_dz;
  logic [WIDTH-1:0]   r_a_raw;
  logic [WIDTH-1:0]   r_opnd;
  logic [2*WIDTH-1:0] r_part;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;

  logic               w_sgn;
  logic               w_is_div;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [2*WIDTH-1:0] w_step_part;
  logic               w_step_q;
  logic [2*WIDTH-1:0] w_neg_prod;
  logic [WIDTH-1:0]   w_fix_hi;
  logic [WIDTH-1:0]   w_fix_lo;

  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v, input logic sgn);
    if (sgn && v[WIDTH-1]) begin
      abs_val = -v;
    end else begin
      abs_val = v;
    end
  endfunction

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .i_div  (r_div),
    .i_part (r_part),
    .i_opnd (r_opnd),
    .o_part (w_step_part),
    .o_qbit (w_step_q)
  );

  // Operand decode at issue
  always_comb begin
    w_sgn    = (op == OP_MULT) || (op == OP_DIV);
    w_is_div = (op == OP_DIVU) || (op == OP_DIV);
    w_abs_a  = abs_val(a, w_sgn);
    w_abs_b  = abs_val(b, w_sgn);
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start && !flush) w_next = S_CALC;
        else                 w_next = S_IDLE;
      end
      S_CALC: begin
        if (flush)                            w_next = S_IDLE;
        else if (r_cnt == CNT_W'(WIDTH - 1))  w_next = S_FIX;
        else                                  w_next = S_CALC;
      end
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Sign correction of the raw unsigned result; divide-by-zero bypasses it
  always_comb begin
    w_neg_prod = -r_part;
    w_fix_hi   = r_part[2*WIDTH-1:WIDTH];
    w_fix_lo   = r_part[WIDTH-1:0];
    if (!r_div) begin
      if (r_neg_q) begin
        w_fix_hi = w_neg_prod[2*WIDTH-1:WIDTH];
        w_fix_lo = w_neg_prod[WIDTH-1:0];
      end else begin
        w_fix_hi = r_part[2*WIDTH-1:WIDTH];
        w_fix_lo = r_part[WIDTH-1:0];
      end
    end else if (r_dz) begin
      w_fix_hi = r_a_raw;
      w_fix_lo = {WIDTH{1'b1}};
    end else begin
      w_fix_lo = r_neg_q ? -r_part[WIDTH-1:0] : r_part[WIDTH-1:0];
      w_fix_hi = r_neg_r ? -r_part[2*WIDTH-1:WIDTH] : r_part[2*WIDTH-1:WIDTH];
    end
  end

  // Datapath, counter, HI/LO and done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= {CNT_W{1'b0}};
      r_div   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz    <= 1'b0;
      r_a_raw <= {WIDTH{1'b0}};
      r_opnd  <= {WIDTH{1'b0}};
      r_part  <= {(2*WIDTH){1'b0}};
      r_hi    <= {WIDTH{1'b0}};
      r_lo    <= {WIDTH{1'b0}};
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (!flush) begin
              r_cnt   <= {CNT_W{1'b0}};
              r_div   <= w_is_div;
              r_neg_q <= w_sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
              r_neg_r <= w_sgn & a[WIDTH-1];
              r_dz    <= w_is_div & (b == {WIDTH{1'b0}});
              r_a_raw <= a;
              // Divide keeps the dividend in the low half; multiply keeps the multiplier there
              if (w_is_div) begin
                r_part <= {{WIDTH{1'b0}}, w_abs_a};
                r_opnd <= w_abs_b;
              end else begin
                r_part <= {{WIDTH{1'b0}}, w_abs_b};
                r_opnd <= w_abs_a;
              end
            end
          end else begin
            if (mthi) r_hi <= wdata;
            if (mtlo) r_lo <= wdata;
          end
        end
        S_CALC: begin
          if (!flush) begin
            r_part <= {w_step_part[2*WIDTH-1:1], w_step_part[0] | w_step_q};
            r_cnt  <= r_cnt + CNT_W'(1);
          end
        end
        S_FIX: begin
          if (!flush) begin
            r_hi   <= w_fix_hi;
            r_lo   <= w_fix_lo;
            r_done <= 1'b1;
          end
        end
        default: begin
          r_done <= 1'b0;
        end
      endcase
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule
